// File: rtl/reg_rename_file.sv
// Architectural register file with per-register ROB rename tags.
// Operands resolve from the file, the in-flight commit, or the ROB query port.
module reg_rename_file #(
   parameter int TAG_W = 4,
   parameter int NREG  = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   input  logic             clear,
   input  logic             issue_ok,
   input  logic [4:0]       issue_rd,
   input  logic [TAG_W-1:0] issue_tag,
   input  logic             commit_ok,
   input  logic [TAG_W-1:0] commit_tag,
   input  logic [4:0]       commit_addr,
   input  logic [31:0]      commit_val,
   input  logic [4:0]       rs1,
   input  logic [4:0]       rs2,
   output logic [TAG_W-1:0] rob_q1,
   output logic [TAG_W-1:0] rob_q2,
   input  logic             rob_q1_ok,
   input  logic             rob_q2_ok,
   input  logic [31:0]      rob_v1,
   input  logic [31:0]      rob_v2,
   output logic             rs1_rdy,
   output logic             rs2_rdy,
   output logic [31:0]      rs1_val,
   output logic [31:0]      rs2_val,
   output logic [TAG_W-1:0] rs1_tag,
   output logic [TAG_W-1:0] rs2_tag
);

   localparam int DATA_W = 32;

   typedef struct packed {
      logic              rdy;
      logic [DATA_W-1:0] val;
      logic [TAG_W-1:0]  tag;
   } opnd_t;

   logic [DATA_W-1:0] regs [NREG];
   logic [NREG-1:0]   busy;
   logic [TAG_W-1:0]  tags [NREG];

   // Priority: x0, committed file value, commit bypass, ROB completed value, pending tag.
   function automatic opnd_t resolve(
      input logic [4:0]        rs,
      input logic              rs_busy,
      input logic [DATA_W-1:0] rs_reg,
      input logic [TAG_W-1:0]  rs_tag,
      input logic              q_ok,
      input logic [DATA_W-1:0] q_val,
      input logic              c_ok,
      input logic [4:0]        c_addr,
      input logic [TAG_W-1:0]  c_tag,
      input logic [DATA_W-1:0] c_val
   );
      opnd_t o;
      o = '0;
      if (rs == 5'd0) begin
         o.rdy = 1'b1;
      end else if (!rs_busy) begin
         o.rdy = 1'b1;
         o.val = rs_reg;
      end else if (c_ok && (c_addr == rs) && (c_tag == rs_tag)) begin
         o.rdy = 1'b1;
         o.val = c_val;
      end else if (q_ok) begin
         o.rdy = 1'b1;
         o.val = q_val;
      end else begin
         o.tag = rs_tag;
      end
      return o;
   endfunction

   // Entry 0 is only ever written by reset, which keeps x0 zero and never busy.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy <= '0;
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
            tags[i] <= '0;
         end
      end else if (rdy) begin
         for (int i = 1; i < NREG; i++) begin
            if (commit_ok && (commit_addr == 5'(i)))
               regs[i] <= commit_val;
            if (clear) begin
               busy[i] <= 1'b0;
            end else if (issue_ok && (issue_rd == 5'(i))) begin
               busy[i] <= 1'b1;
               tags[i] <= issue_tag;
            end else if (commit_ok && (commit_addr == 5'(i)) && busy[i] && (tags[i] == commit_tag)) begin
               busy[i] <= 1'b0;
            end
         end
      end
   end

   opnd_t op1, op2;

   always_comb begin
      op1 = resolve(rs1, busy[rs1], regs[rs1], tags[rs1], rob_q1_ok, rob_v1,
                    commit_ok, commit_addr, commit_tag, commit_val);
      op2 = resolve(rs2, busy[rs2], regs[rs2], tags[rs2], rob_q2_ok, rob_v2,
                    commit_ok, commit_addr, commit_tag, commit_val);
   end

   assign rob_q1  = tags[rs1];
   assign rob_q2  = tags[rs2];
   assign rs1_rdy = op1.rdy;
   assign rs1_val = op1.val;
   assign rs1_tag = op1.tag;
   assign rs2_rdy = op2.rdy;
   assign rs2_val = op2.val;
   assign rs2_tag = op2.tag;

endmodule

// File: tb/tb_reg_rename_file.sv
// Bench for reg_rename_file: scenario tasks push expected operand results
// into a scoreboard queue and pop/compare them once the outputs settle.
module tb_reg_rename_file;

   localparam int TAG_W = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             rdy = 1'b1;
   logic             clear = 1'b0;
   logic             issue_ok = 1'b0;
   logic [4:0]       issue_rd = '0;
   logic [TAG_W-1:0] issue_tag = '0;
   logic             commit_ok = 1'b0;
   logic [TAG_W-1:0] commit_tag = '0;
   logic [4:0]       commit_addr = '0;
   logic [31:0]      commit_val = '0;
   logic [4:0]       rs1 = '0;
   logic [4:0]       rs2 = '0;
   logic [TAG_W-1:0] rob_q1, rob_q2;
   logic             rob_q1_ok = 1'b0;
   logic             rob_q2_ok = 1'b0;
   logic [31:0]      rob_v1 = '0;
   logic [31:0]      rob_v2 = '0;
   logic             rs1_rdy, rs2_rdy;
   logic [31:0]      rs1_val, rs2_val;
   logic [TAG_W-1:0] rs1_tag, rs2_tag;

   reg_rename_file #(.TAG_W(TAG_W), .NREG(32)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
      .issue_ok(issue_ok), .issue_rd(issue_rd), .issue_tag(issue_tag),
      .commit_ok(commit_ok), .commit_tag(commit_tag), .commit_addr(commit_addr),
      .commit_val(commit_val), .rs1(rs1), .rs2(rs2),
      .rob_q1(rob_q1), .rob_q2(rob_q2), .rob_q1_ok(rob_q1_ok), .rob_q2_ok(rob_q2_ok),
      .rob_v1(rob_v1), .rob_v2(rob_v2),
      .rs1_rdy(rs1_rdy), .rs2_rdy(rs2_rdy), .rs1_val(rs1_val), .rs2_val(rs2_val),
      .rs1_tag(rs1_tag), .rs2_tag(rs2_tag)
   );

   always #5 clk = ~clk;

   // Scoreboard entry: port 0/1 = rs1/rs2 {rdy,val,tag}; port 2/3 = rob_q1/rob_q2.
   typedef struct {
      string       name;
      int          port;
      logic [36:0] exp;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   function automatic void push_op(string name, int port, logic r, logic [31:0] v, logic [3:0] t);
      exp_t e;
      e.name = name;
      e.port = port;
      e.exp  = {r, v, t};
      sb.push_back(e);
   endfunction

   function automatic void push_q(string name, int port, logic [3:0] t);
      exp_t e;
      e.name = name;
      e.port = port;
      e.exp  = {33'd0, t};
      sb.push_back(e);
   endfunction

   function automatic logic [36:0] observe(int port);
      case (port)
         0:       return {rs1_rdy, rs1_val, rs1_tag};
         1:       return {rs2_rdy, rs2_val, rs2_tag};
         2:       return {33'd0, rob_q1};
         default: return {33'd0, rob_q2};
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      issue_ok  = 1'b0;
      commit_ok = 1'b0;
      clear     = 1'b0;
      rob_q1_ok = 1'b0;
      rob_q2_ok = 1'b0;
      rob_v1    = '0;
      rob_v2    = '0;
   endtask

   task automatic issue(logic [4:0] rd, logic [3:0] t);
      issue_ok  = 1'b1;
      issue_rd  = rd;
      issue_tag = t;
   endtask

   task automatic commit(logic [4:0] a, logic [3:0] t, logic [31:0] v);
      commit_ok   = 1'b1;
      commit_addr = a;
      commit_tag  = t;
      commit_val  = v;
   endtask

   task automatic test_reset();
      exp_t e;
      logic [36:0] obs;
      rs1 = 5'd5;
      rs2 = 5'd31;
      #2;
      push_op("reset_rs1_x5", 0, 1'b1, 32'h0, 4'h0);
      push_op("reset_rs2_x31", 1, 1'b1, 32'h0, 4'h0);
      push_q("reset_q1", 2, 4'h0);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = observe(e.port); n_chk++;
         if (obs !== e.exp) $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
         else n_pass++;
      end
      step();
      rst = 1'b1;
      issue(5'd0, 4'd3);
      step();
      idle();
      rs1 = 5'd0;
      push_op("x0_after_issue", 0, 1'b1, 32'h0, 4'h0);
      push_q("x0_q1_tag", 2, 4'h0);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = observe(e.port); n_chk++;
         if (obs !== e.exp) $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
         else n_pass++;
      end
   endtask

   task automatic test_rename_commit();
      exp_t e;
      logic [36:0] obs;
      issue(5'd5, 4'd7);
      step();
      idle();
      rs1 = 5'd5;
      push_op("renamed_x5_pending", 0, 1'b0, 32'h0, 4'd7);
      push_q("renamed_x5_q1", 2, 4'd7);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = observe(e.port); n_chk++;
         if (obs !== e.exp) $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
         else n_pass++;
      end
      commit(5'd5, 4'd7, 32'hDEADBEEF);
      push_op("commit_bypass_x5", 0, 1'b1, 32'hDEADBEEF, 4'h0);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = observe(e.port); n_chk++;
         if (obs !== e.exp) $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
         else n_pass++;
      end
      step();
      idle();
      rob_q1_ok = 1'b1;
      rob_v1    = 32'h0000_0123;
      push_op("x5_from_file", 0, 1'b1, 32'hDEADBEEF, 4'h0);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = observe(e.port); n_chk++;
         if (obs !== e.exp) $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
         else n_pass++;
      end
   endtask

   task automatic test_stale_commit();
      exp_t e;
      logic [36:0] obs;
      idle();
      issue(5'd5, 4'd2);
      step();
      issue(5'd5, 4'd9);
      step();
      idle();
      commit(5'd5, 4'd2, 32'h11);
      rs2 = 5'd5;
      push_op("stale_no_bypass", 1, 1'b0, 32'h0, 4'd9);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = observe(e.port); n_chk++;
         if (obs !== e.exp) $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
         else n_pass++;
      end
      step();
      idle();
      push_op("stale_still_busy", 1, 1'b0, 32'h0, 4'd9);
      push_q("stale_q2_tag", 3, 4'd9);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = observe(e.port); n_chk++;
         if (obs !== e.exp) $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
         else n_pass++;
      end
      rs1       = 5'd5;
      rob_q1_ok = 1'b1;
      rob_v1    = 32'h22;
      push_op("rob_value_x5", 0, 1'b1, 32'h22, 4'h0);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = observe(e.port); n_chk++;
         if (obs !== e.exp) $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      logic [36:0] obs;
      step();
      idle();
      issue(5'd6, 4'd4);
      step();
      commit(5'd6, 4'd4, 32'h33);
      issue(5'd6, 4'd5);
      rs2 = 5'd6;
      push_op("same_cycle_bypass_x6", 1, 1'b1, 32'h33, 4'h0);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = observe(e.port); n_chk++;
         if (obs !== e.exp) $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
         else n_pass++;
      end
      step();
      idle();
      push_op("issue_wins_x6", 1, 1'b0, 32'h0, 4'd5);
      push_q("issue_wins_q2", 3, 4'd5);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = observe(e.port); n_chk++;
         if (obs !== e.exp) $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
         else n_pass++;
      end
   endtask

   task automatic test_flush();
      exp_t e;
      logic [36:0] obs;
      issue(5'd1, 4'd1);
      step();
      issue(5'd2, 4'd2);
      step();
      issue(5'd3, 4'd3);
      step();
      idle();
      rs1 = 5'd1;
      rs2 = 5'd3;
      push_op("pre_flush_x1", 0, 1'b0, 32'h0, 4'd1);
      push_op("pre_flush_x3", 1, 1'b0, 32'h0, 4'd3);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = observe(e.port); n_chk++;
         if (obs !== e.exp) $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
         else n_pass++;
      end
      clear = 1'b1;
      commit(5'd1, 4'd1, 32'h44);
      issue(5'd7, 4'd8);
      step();
      idle();
      rs1 = 5'd1;
      rs2 = 5'd7;
      push_op("flush_x1_val", 0, 1'b1, 32'h44, 4'h0);
      push_op("flush_x7_not_busy", 1, 1'b1, 32'h0, 4'h0);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = observe(e.port); n_chk++;
         if (obs !== e.exp) $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
         else n_pass++;
      end
      for (int r = 2; r <= 6; r++) begin
         rs1 = 5'(r);
         #1;
         obs = observe(0);
         n_chk++;
         case (r)
            5:       e.exp = {1'b1, 32'h11, 4'h0};
            6:       e.exp = {1'b1, 32'h33, 4'h0};
            default: e.exp = {1'b1, 32'h0, 4'h0};
         endcase
         if (obs !== e.exp) $display("FAIL flush_x%0d: got %h expected %h", r, obs, e.exp);
         else n_pass++;
      end
   endtask

   task automatic test_stall();
      exp_t e;
      logic [36:0] obs;
      step();
      rdy = 1'b0;
      issue(5'd8, 4'd6);
      commit(5'd9, 4'd0, 32'h55);
      step();
      idle();
      rs1 = 5'd8;
      rs2 = 5'd9;
      push_op("stall_x8_not_busy", 0, 1'b1, 32'h0, 4'h0);
      push_op("stall_x9_unwritten", 1, 1'b1, 32'h0, 4'h0);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = observe(e.port); n_chk++;
         if (obs !== e.exp) $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
         else n_pass++;
      end
      step();
      rdy = 1'b1;
      issue(5'd8, 4'd6);
      step();
      idle();
      commit(5'd9, 4'd0, 32'h55);
      step();
      idle();
      push_op("resume_x8_busy", 0, 1'b0, 32'h0, 4'd6);
      push_op("resume_x9_written", 1, 1'b1, 32'h55, 4'h0);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = observe(e.port); n_chk++;
         if (obs !== e.exp) $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
         else n_pass++;
      end
   endtask

   task automatic test_async_reset();
      exp_t e;
      logic [36:0] obs;
      #2;
      rst = 1'b0;
      #1;
      push_op("async_rst_x8", 0, 1'b1, 32'h0, 4'h0);
      push_op("async_rst_x9", 1, 1'b1, 32'h0, 4'h0);
      push_q("async_rst_q1", 2, 4'h0);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = observe(e.port); n_chk++;
         if (obs !== e.exp) $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
         else n_pass++;
      end
      step();
      rst = 1'b1;
   endtask

   initial begin
      test_reset();
      test_rename_commit();
      test_stale_commit();
      test_back_to_back();
      test_flush();
      test_stall();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/reg_rename_file.md
# reg_rename_file

Architectural register file with per-register rename tags. It sits on the receiving end of the reorder buffer's commit interface and serves the decoder's operand lookups. It records which ROB entry will produce each register, retires committed values into the 32×32-bit file, and resolves operands from three sources: the register file, the commit in flight, or the ROB's completed-value query port. A ROB flush drops all rename tags in one cycle.

## Interface
Parameters:
- `TAG_W`, 4: ROB tag width (16-entry ROB).
- `NREG`, 32: architectural register count; x0 hardwired to zero.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `rdy`  in  1  global ready; when 0, all state holds.
- `clear`  in  1  ROB flush: drop every rename tag.
- `issue_ok`  in  1  decoder renames a destination this cycle.
- `issue_rd`  in  5  destination register being renamed.
- `issue_tag`  in  TAG_W  ROB entry allocated to `issue_rd`.
- `commit_ok`  in  1  ROB retires a register-writing instruction.
- `commit_tag`  in  TAG_W  ROB entry being retired.
- `commit_addr`  in  5  destination register of the retiring entry.
- `commit_val`  in  32  retired value.
- `rs1`, `rs2`  in  5 each  decoder source-register selects.
- `rob_q1`, `rob_q2`  out  TAG_W each  ROB query tags; equal to `tag[rs1]` and `tag[rs2]`.
- `rob_q1_ok`, `rob_q2_ok`  in  1 each  ROB reports the queried entry has completed.
- `rob_v1`, `rob_v2`  in  32 each  ROB value for the queried entry.
- `rs1_rdy`, `rs2_rdy`  out  1 each  operand value is available.
- `rs1_val`, `rs2_val`  out  32 each  operand value; 0 when not ready.
- `rs1_tag`, `rs2_tag`  out  TAG_W each  producing ROB tag when not ready; 0 when ready.

## Operation
State:
- `regs[32]` of 32 bits.
- `busy[32]`.
- `tag[32]` of TAG_W bits.

Sequential update, applied on the rising edge only when `rst`=1 and `rdy`=1:
- **Commit.** If `commit_ok` and `commit_addr`≠0:
  - Write `regs[commit_addr]` ← `commit_val`.
  - If `busy[commit_addr]` and `tag[commit_addr]`==`commit_tag`, clear `busy[commit_addr]`. A newer rename of the same register is not disturbed.
  - Commit is performed even when `clear`=1.
- **Issue.** If `issue_ok`, `issue_rd`≠0 and `clear`=0: `busy[issue_rd]`←1 and `tag[issue_rd]`←`issue_tag`.
  - When issue and commit target the same register in the same cycle, issue wins: busy stays 1 with the new tag, and the commit value is still written.
- **Clear.** If `clear`=1: all `busy` bits ← 0 and `issue_ok` is ignored. `regs` are untouched except by a same-cycle commit.
- When `rdy`=0, no state changes. Combinational outputs still track their inputs.
- Register 0 is never busy, is never written, and always reads 0.

Operand resolution is combinational and identical for rs1 and rs2. It uses state from before this cycle's issue, so `add x1,x1,x1` reads the old mapping. The first matching rule applies:
1. rs==0: rdy=1, val=0, tag=0.
2. `busy[rs]`=0: rdy=1, val=`regs[rs]`.
3. `commit_ok` and `commit_addr`==rs and `commit_tag`==`tag[rs]`: rdy=1, val=`commit_val` (commit bypass).
4. `rob_q_ok`=1: rdy=1, val=`rob_v`.
5. Otherwise: rdy=0, val=0, tag=`tag[rs]`.

When `clear`=1, operand outputs are don't-care; the decoder discards them.

## Timing
- Asynchronous reset (`rst`=0): all `regs`, `busy` and `tag` go to 0 immediately. Consequently every `rs*_rdy`=1, `rs*_val`=0, `rs*_tag`=0, and `rob_q*`=0. Reset asserted mid-operation discards all renames with no partial updates.
- Read latency is 0 cycles. An issue becomes visible to lookups the cycle after its rising edge. A commit is visible the same cycle through the bypass and through the file on the next cycle.
- `clear` takes effect at the edge on which it is sampled. The next cycle sees every register ready with its committed value.
- Inputs are sampled only on the rising edge. There is no back-pressure; the block accepts one issue and one commit every cycle.

## Test plan
- **Reset:** drive `rst`=0 then 1, read rs1=5 and rs2=31 → rdy=1, val=0. Issue rd=0 with tag 3, then read rs1=0 → rdy=1, val=0.
- **Rename and commit:** issue x5 with tag 7. Next cycle read rs1=5 with `rob_q1_ok`=0 → rdy=0, tag=7. Then commit tag 7, addr 5, val 0xDEADBEEF → same-cycle rdy=1, val 0xDEADBEEF. The following cycle `busy[5]`=0 and the value reads from the file.
- **Stale commit:** issue x5 tag 2, then issue x5 tag 9. Commit tag 2, val 0x11 → `regs[5]`=0x11 and x5 stays busy with tag 9. ROB query `rob_q1_ok`=1 with `rob_v1`=0x22 → rdy=1, val 0x22.
- **Same-cycle issue and commit:** x6 busy with tag 4. In one cycle, commit tag 4 val 0x33 and issue x6 tag 5 → next cycle x6 busy with tag 5 and `regs[6]`=0x33.
- **Flush:** x1, x2 and x3 busy. Assert `clear` together with a commit to x1 of val 0x44 and an issue to x7 → next cycle all registers ready, x1=0x44, x7 not busy.
- **Stall:** hold `rdy`=0 and pulse an issue to x8 and a commit to x9 → no state change. Raise `rdy` → normal operation resumes.
